// File: rtl/bmu_pipe_if.sv
// Issue/writeback-side bundle for bmu_pipe: request, result and debug-counter signals.
// The master side is the issue stage together with the downstream consumer; the slave side is the unit.
interface bmu_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
);
  logic             scan_mode;
  logic             valid_in;
  logic             ready_out;
  logic [3:0]       op_in;
  logic             csr_ren_in;
  logic [XLEN-1:0]  csr_rddata_in;
  logic [XLEN-1:0]  a_in;
  logic [XLEN-1:0]  b_in;
  logic             valid_out;
  logic             ready_in;
  logic [XLEN-1:0]  result_ff;
  logic             error;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;

  modport master (
    output scan_mode, valid_in, op_in, csr_ren_in, csr_rddata_in, a_in, b_in,
           ready_in, err_clr,
    input  ready_out, valid_out, result_ff, error, err_cnt
  );

  modport slave (
    input  scan_mode, valid_in, op_in, csr_ren_in, csr_rddata_in, a_in, b_in,
           ready_in, err_clr,
    output ready_out, valid_out, result_ff, error, err_cnt
  );
endinterface

// File: rtl/bmu_pipe.sv
// Pipelined bit-manipulation unit: logic, rotate, count and min/max ops computed in stage 1,
// carried through a STAGES-deep global-stall pipeline, with a saturating illegal-op counter.
module bmu_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8
) (
  input logic       clk,
  input logic       rst_l,
  bmu_pipe_if.slave bus
);
  localparam int unsigned SH_W = $clog2(XLEN);
  localparam int unsigned CW   = SH_W + 1;

  typedef struct packed {
    logic            vld;
    logic            err;
    logic [XLEN-1:0] res;
  } stage_t;

  stage_t           pipe_q [STAGES];
  stage_t           stage_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             advance;
  logic             accept;
  logic [SH_W-1:0]  sh;
  logic [CW-1:0]    rsh;
  logic [XLEN-1:0]  rol_v, ror_v;
  logic [CW-1:0]    clz, ctz, cpop;
  logic [XLEN-1:0]  res_c;
  logic             err_c;

  // Whole pipeline moves only when the output slot is free or being drained.
  assign advance = !bus.scan_mode && (!pipe_q[STAGES-1].vld || bus.ready_in);
  assign accept  = bus.valid_in && advance;

  assign sh    = bus.b_in[SH_W-1:0];
  assign rsh   = CW'(XLEN) - CW'(sh);
  // A right/left shift by XLEN yields zero, so sh = 0 returns a unchanged.
  assign rol_v = (bus.a_in << sh) | (bus.a_in >> rsh);
  assign ror_v = (bus.a_in >> sh) | (bus.a_in << rsh);

  always_comb begin
    clz  = CW'(XLEN);
    ctz  = CW'(XLEN);
    cpop = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (bus.a_in[i])          clz = CW'(XLEN - 1 - i);
      if (bus.a_in[XLEN-1-i])   ctz = CW'(XLEN - 1 - i);
      cpop = cpop + CW'(bus.a_in[i]);
    end
  end

  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    unique case (bus.op_in)
      4'd0:  res_c = bus.a_in & bus.b_in;
      4'd1:  res_c = bus.a_in | bus.b_in;
      4'd2:  res_c = bus.a_in ^ bus.b_in;
      4'd3:  res_c = bus.a_in & ~bus.b_in;
      4'd4:  res_c = bus.a_in | ~bus.b_in;
      4'd5:  res_c = ~(bus.a_in ^ bus.b_in);
      4'd6:  res_c = rol_v;
      4'd7:  res_c = ror_v;
      4'd8:  res_c = XLEN'(clz);
      4'd9:  res_c = XLEN'(ctz);
      4'd10: res_c = XLEN'(cpop);
      4'd11: res_c = ($signed(bus.a_in) < $signed(bus.b_in)) ? bus.a_in : bus.b_in;
      4'd12: res_c = ($signed(bus.a_in) < $signed(bus.b_in)) ? bus.b_in : bus.a_in;
      4'd13: res_c = (bus.a_in < bus.b_in) ? bus.a_in : bus.b_in;
      4'd14: res_c = (bus.a_in < bus.b_in) ? bus.b_in : bus.a_in;
      default: begin
        res_c = '0;
        err_c = 1'b1;
      end
    endcase
    if (bus.csr_ren_in) begin
      res_c = bus.csr_rddata_in;
      err_c = 1'b0;
    end
  end

  always_comb begin
    stage_d     = '0;
    stage_d.vld = accept;
    stage_d.err = err_c;
    stage_d.res = res_c;
  end

  // Bubbles travel with the data; nothing is collapsed on a stall.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int s = 0; s < STAGES; s++) pipe_q[s] <= '0;
    end else if (advance) begin
      pipe_q[0] <= stage_d;
      for (int s = 1; s < STAGES; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  // Clear wins over a coincident increment; increment stops at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_clr)
      err_cnt_d = '0;
    else if (accept && err_c && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign bus.ready_out = advance;
  assign bus.valid_out = pipe_q[STAGES-1].vld;
  assign bus.result_ff = pipe_q[STAGES-1].res;
  assign bus.error     = pipe_q[STAGES-1].err;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_bmu_pipe.sv
// Randomised and directed bench for bmu_pipe against a token-queue reference model.
// A second instance with a 2-bit error counter shares all inputs to exercise saturation.
module tb_bmu_pipe;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CNT_W2 = 2;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  bmu_pipe_if #(.XLEN(XLEN), .CNT_W(CNT_W))  bus ();
  bmu_pipe_if #(.XLEN(XLEN), .CNT_W(CNT_W2)) bus2 ();

  bmu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  bmu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .CNT_W(CNT_W2)) u_dut_sat (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus2)
  );

  assign bus2.scan_mode     = bus.scan_mode;
  assign bus2.valid_in      = bus.valid_in;
  assign bus2.op_in         = bus.op_in;
  assign bus2.csr_ren_in    = bus.csr_ren_in;
  assign bus2.csr_rddata_in = bus.csr_rddata_in;
  assign bus2.a_in          = bus.a_in;
  assign bus2.b_in          = bus.b_in;
  assign bus2.ready_in      = bus.ready_in;
  assign bus2.err_clr       = bus.err_clr;

  typedef struct {
    bit          v;
    logic [3:0]  op;
    bit          csr;
    logic [31:0] cd;
    logic [31:0] a;
    logic [31:0] b;
    bit          rdy;
    bit          scan;
    bit          clr;
    bit          rst;
    bit          has_k;
    logic [31:0] k;
  } stim_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          age;
    bit          has_k;
    logic [31:0] k;
  } tok_t;

  tok_t q[$];
  int   cnt_m  = 0;
  int   cnt2_m = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{v: 1'b0, op: 4'd0, csr: 1'b0, cd: 32'd0, a: 32'd0, b: 32'd0,
          rdy: 1'b1, scan: 1'b0, clr: 1'b0, rst: 1'b0, has_k: 1'b0, k: 32'd0};
    return s;
  endfunction

  function automatic stim_t req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] k);
    stim_t s;
    s = idle();
    s.v = 1'b1; s.op = op; s.a = a; s.b = b; s.has_k = 1'b1; s.k = k;
    return s;
  endfunction

  // Reference semantics straight from the operation table.
  function automatic void ref_op(input stim_t s, output logic [31:0] r, output logic e);
    int sh;
    int n;
    int sa;
    int sb;
    sh = int'(s.b % XLEN);
    sa = int'(s.a);
    sb = int'(s.b);
    r  = 32'd0;
    e  = 1'b0;
    case (s.op)
      4'd0:  r = s.a & s.b;
      4'd1:  r = s.a | s.b;
      4'd2:  r = s.a ^ s.b;
      4'd3:  r = s.a & ~s.b;
      4'd4:  r = s.a | ~s.b;
      4'd5:  r = ~(s.a ^ s.b);
      4'd6:  r = (sh == 0) ? s.a : ((s.a << sh) | (s.a >> (XLEN - sh)));
      4'd7:  r = (sh == 0) ? s.a : ((s.a >> sh) | (s.a << (XLEN - sh)));
      4'd8: begin
        n = 0;
        while (n < XLEN && !s.a[XLEN-1-n]) n++;
        r = 32'(n);
      end
      4'd9: begin
        n = 0;
        while (n < XLEN && !s.a[n]) n++;
        r = 32'(n);
      end
      4'd10: r = 32'($countones(s.a));
      4'd11: r = (sa < sb) ? s.a : s.b;
      4'd12: r = (sa < sb) ? s.b : s.a;
      4'd13: r = (s.a < s.b) ? s.a : s.b;
      4'd14: r = (s.a < s.b) ? s.b : s.a;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    if (s.csr) begin
      r = s.cd;
      e = 1'b0;
    end
  endfunction

  // One clock: check outputs, drive inputs, then advance the model across the coming edge.
  task automatic step(input stim_t s);
    bit          ev;
    bit          adv;
    bit          acc;
    logic [31:0] r;
    logic        e;
    tok_t        t;
    @(negedge clk);
    ev = (q.size() > 0) && (q[0].age == STAGES);
    chk("valid_out", bus.valid_out, ev);
    if (ev) begin
      chk("result_ff", bus.result_ff, q[0].res);
      chk("error", bus.error, q[0].err);
      if (q[0].has_k) chk("result_known", bus.result_ff, q[0].k);
    end
    chk("err_cnt", bus.err_cnt, cnt_m);
    chk("err_cnt_sat", bus2.err_cnt, cnt2_m);

    rst_l             = !s.rst;
    bus.valid_in      = s.v;
    bus.op_in         = s.op;
    bus.csr_ren_in    = s.csr;
    bus.csr_rddata_in = s.cd;
    bus.a_in          = s.a;
    bus.b_in          = s.b;
    bus.ready_in      = s.rdy;
    bus.scan_mode     = s.scan;
    bus.err_clr       = s.clr;
    #1;
    adv = !s.scan && (!ev || s.rdy);
    if (!s.rst) chk("ready_out", bus.ready_out, adv);

    if (s.rst) begin
      q.delete();
      cnt_m  = 0;
      cnt2_m = 0;
    end else begin
      acc = s.v && adv;
      ref_op(s, r, e);
      if (s.clr) begin
        cnt_m  = 0;
        cnt2_m = 0;
      end else if (acc && e) begin
        if (cnt_m  < (1 << CNT_W)  - 1) cnt_m++;
        if (cnt2_m < (1 << CNT_W2) - 1) cnt2_m++;
      end
      if (adv) begin
        if (ev) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) begin
          t = '{res: r, err: e, age: 1, has_k: s.has_k, k: s.k};
          q.push_back(t);
        end
      end
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.v    = ($urandom_range(0, 3) != 0);
    s.op   = 4'($urandom_range(0, 15));
    s.csr  = ($urandom_range(0, 7) == 0);
    s.cd   = $urandom;
    case ($urandom_range(0, 3))
      0:       s.a = 32'd0;
      1:       s.a = $urandom >> $urandom_range(0, 31);
      2:       s.a = $urandom << $urandom_range(0, 31);
      default: s.a = $urandom;
    endcase
    s.b    = ($urandom_range(0, 3) == 0) ? s.a : $urandom;
    s.rdy  = ($urandom_range(0, 3) != 0);
    s.scan = ($urandom_range(0, 15) == 0);
    s.clr  = ($urandom_range(0, 31) == 0);
    s.rst  = ($urandom_range(0, 199) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;

    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    idle_n(1);
    chk("reset_result", bus.result_ff, 32'd0);
    chk("reset_error", bus.error, 1'b0);

    step(req(4'd2, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0));
    idle_n(3);

    step(req(4'd6, 32'h8000_0001, 32'd1, 32'h0000_0003));
    step(req(4'd7, 32'h8000_0001, 32'd4, 32'h1800_0000));
    idle_n(3);

    step(req(4'd8,  32'h0000_0000, 32'd0, 32'd32));
    step(req(4'd9,  32'h0000_0100, 32'd0, 32'd8));
    step(req(4'd10, 32'hFFFF_FFFF, 32'd0, 32'd32));
    step(req(4'd11, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF));
    step(req(4'd13, 32'hFFFF_FFFF, 32'd1, 32'd1));
    idle_n(3);

    // Downstream backpressure for three cycles in the middle of a stream.
    for (int i = 0; i < 9; i++) begin
      s = rnd();
      s.v = 1'b1; s.scan = 1'b0; s.clr = 1'b0; s.rst = 1'b0;
      s.rdy = !(i >= 2 && i <= 4);
      step(s);
    end
    idle_n(3);

    for (int i = 0; i < 3; i++) step(req(4'd15, $urandom, $urandom, 32'd0));
    idle_n(3);
    chk("err_cnt_three", bus.err_cnt, 8'd3);
    for (int i = 0; i < 2; i++) step(req(4'd15, $urandom, $urandom, 32'd0));
    idle_n(3);
    chk("err_cnt_sat_three", bus2.err_cnt, 2'd3);
    s = req(4'd15, 32'd0, 32'd0, 32'd0); s.clr = 1'b1;
    step(s);
    idle_n(3);

    s = req(4'd15, 32'h1234_5678, 32'd0, 32'hDEAD_BEEF);
    s.csr = 1'b1; s.cd = 32'hDEAD_BEEF;
    step(s);
    idle_n(3);

    for (int i = 0; i < 10; i++) begin
      s = rnd();
      s.v = 1'b1; s.rdy = 1'b1; s.clr = 1'b0; s.rst = 1'b0;
      s.scan = (i >= 3 && i <= 6);
      step(s);
    end
    idle_n(3);

    for (int i = 0; i < 3; i++) step(req(4'd15, $urandom, $urandom, 32'd0));
    s = idle(); s.rst = 1'b1;
    step(s);
    idle_n(2);

    for (int i = 0; i < 3000; i++) step(rnd());
    idle_n(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bmu_pipe.md
Name: bmu_pipe

Overview:
Parametrised, pipelined successor to the single-cycle bit-manipulation unit. It accepts one operation per cycle over a valid/ready handshake and computes a logic, rotate, count or min/max result on XLEN-bit operands. The result passes through a STAGES-deep stall-able pipeline. The block sits between the decode/issue stage and writeback. It flags illegal opcodes and keeps a saturating error count for debug and coverage.

Parameters:
XLEN, 32, operand/result width; power of 2, range 8..64
STAGES, 2, pipeline depth in cycles; range 1..4
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock
rst_l  input  1  synchronous active-low reset
scan_mode  input  1  freezes the pipeline when 1
valid_in  input  1  request valid
ready_out  output  1  block can accept a request this cycle
op_in  input  4  operation select
csr_ren_in  input  1  CSR bypass select
csr_rddata_in  input  XLEN  CSR read data
a_in  input  XLEN  operand A (signed for MIN/MAX)
b_in  input  XLEN  operand B
valid_out  output  1  result valid
ready_in  input  1  downstream accepts the result
result_ff  output  XLEN  registered result
error  output  1  registered illegal-op flag, aligned with result_ff
err_cnt  output  CNT_W  saturating count of accepted illegal ops
err_clr  input  1  synchronous clear of err_cnt

Behaviour:
- Clock clk; reset rst_l is synchronous and active-low.
- Reset: all stage valid bits = 0, valid_out = 0, result_ff = 0, error = 0, err_cnt = 0. Reset mid-operation discards all in-flight requests.
- Global-stall pipeline:
  - advance = !scan_mode && (!valid_out || ready_in).
  - ready_out = advance.
  - Accept = valid_in && ready_out.
  - When advance = 1, every stage shifts by one; stage 1 loads {accept, computed result, error}.
  - When advance = 0, all stages hold, including bubbles.
  - Bubbles are not collapsed.
- Latency: a request accepted in cycle N appears on valid_out/result_ff at cycle N+STAGES, absent stalls.
- Output hold: while valid_out = 1 and ready_in = 0, result_ff and error stay stable.
- scan_mode = 1: ready_out = 0 and the pipeline holds. No data is lost or duplicated.
- Computation happens in stage 1 and is combinational on the inputs; shift amount sh = b_in[log2(XLEN)-1:0].
  - 0 AND, 1 OR, 2 XOR.
  - 3 ANDN: a & ~b. 4 ORN: a | ~b. 5 XNOR: ~(a ^ b).
  - 6 ROL by sh. 7 ROR by sh. sh = 0 returns a.
  - 8 CLZ of a; a = 0 gives XLEN.
  - 9 CTZ of a; a = 0 gives XLEN.
  - 10 CPOP of a, zero-extended.
  - 11 MIN signed, 12 MAX signed, 13 MINU, 14 MAXU.
  - 15: illegal. Result = 0, error = 1.
- csr_ren_in = 1 overrides op_in: result = csr_rddata_in, error = 0, even when op_in = 15.
- Error counter:
  - Increments when an accepted request carries error = 1.
  - Saturates at 2^CNT_W-1.
  - err_clr has priority: when err_clr coincides with an increment, the counter becomes 0.
- valid_in = 0 with ready_out = 1 inserts a bubble. Inputs are don't-care when valid_in = 0 and must not change err_cnt.

Test Plan:
- Reset, then XLEN=32, STAGES=2, op=2 (XOR), a=0xF0F0_F0F0, b=0xFFFF_0000, accepted at cycle N -> valid_out=1 at N+2, result_ff=0x0F0F_F0F0, error=0.
- Back-to-back ROL a=0x8000_0001, sh=1 then ROR a=0x8000_0001, sh=4 -> consecutive outputs 0x0000_0003 then 0x1800_0000.
- CLZ a=0 -> 32; CTZ a=0x0000_0100 -> 8; CPOP a=0xFFFF_FFFF -> 32; MIN a=0xFFFF_FFFF, b=1 -> 0xFFFF_FFFF; MINU with the same operands -> 1.
- ready_in held 0 for 3 cycles while a stream is active -> ready_out=0, result_ff unchanged, no requests lost. On release, results exit in order.
- op=15 accepted 3 times -> error=1 on each result and err_cnt=3. With CNT_W=2, 5 illegal ops give err_cnt=3. err_clr asserted together with an illegal op -> err_cnt=0.
- csr_ren_in=1, op=15, csr_rddata=0xDEAD_BEEF -> result 0xDEAD_BEEF, error=0. scan_mode=1 mid-stream -> pipeline frozen. rst_l=0 mid-stream -> valid_out=0 the next cycle, err_cnt=0.
